pregfile_wb_arbiter: RTL and testbench

- Writeback-side initiator for the 64x64 2-read/2-write physical register file.
- Collects results from NUM_SRC execution units (ALU, MDU, LSU) over valid/ready handshakes and buffers one result per source.
- Round-robin arbitration picks up to two results per cycle and drives the register file's two write ports from registers.
- In the same cycle it emits ROB completion (rob index) for each granted result.

---
 rtl/pregfile_wb_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_pregfile_wb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pregfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// pregfile_wb_arbiter
//
// Writeback-side initiator for the 64x64 2-read/2-write physical register
// file. Each execution unit hands its result over a valid/ready handshake into
// a one-deep holding entry. A round-robin arbiter picks up to two held
// entries per cycle. The picked entries go into registered write-port and
// ROB-completion outputs on the next edge.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   flush               drops all held and staged results
//   src_valid/ready     per-source handshake (NUM_SRC bits)
//   src_pdst/data/rob   per-source payload, source i at [i*W +: W]
//   wren0/waddr0/wdata0 register file write port 0 (registered)
//   wren1/waddr1/wdata1 register file write port 1 (registered)
//   cmpl_valid[1:0]     ROB completion valid per port (registered)
//   cmpl_rob0/1         completed ROB index per port (registered)
//   stall_cnt           per-source 32-bit stall counters. This port exists
//                       only when WB_PERF_CNT_EN is defined.
//
// Optional feature macro: WB_PERF_CNT_EN
// -----------------------------------------------------------------------------
module pregfile_wb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int PREG_W  = 6,
    parameter int DATA_W  = 64,
    parameter int ROB_W   = 6
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*PREG_W-1:0]   src_pdst,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC*ROB_W-1:0]    src_rob,
    output logic                        wren0,
    output logic [PREG_W-1:0]           waddr0,
    output logic [DATA_W-1:0]           wdata0,
    output logic                        wren1,
    output logic [PREG_W-1:0]           waddr1,
    output logic [DATA_W-1:0]           wdata1,
    output logic [1:0]                  cmpl_valid,
    output logic [ROB_W-1:0]            cmpl_rob0,
    output logic [ROB_W-1:0]            cmpl_rob1
`ifdef WB_PERF_CNT_EN
    ,
    output logic [NUM_SRC*32-1:0]       stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_SRC);

    // Holding entries, one per source
    logic [NUM_SRC-1:0] hold_vld_q;
    logic [PREG_W-1:0]  hold_pdst_q [NUM_SRC];
    logic [DATA_W-1:0]  hold_data_q [NUM_SRC];
    logic [ROB_W-1:0]   hold_rob_q  [NUM_SRC];

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    // Unpacked views of the flat source buses
    logic [PREG_W-1:0]  in_pdst [NUM_SRC];
    logic [DATA_W-1:0]  in_data [NUM_SRC];
    logic [ROB_W-1:0]   in_rob  [NUM_SRC];
    logic [NUM_SRC-1:0] accept;

    // Arbitration results
    logic               g0_vld, g1_vld;
    logic [IDX_W-1:0]   g0_idx, g1_idx;
    logic [NUM_SRC-1:0] grant;

    // Registered outputs
    logic               wren0_q, wren1_q;
    logic [PREG_W-1:0]  waddr0_q, waddr1_q;
    logic [DATA_W-1:0]  wdata0_q, wdata1_q;
    logic [1:0]         cmpl_valid_q;
    logic [ROB_W-1:0]   cmpl_rob0_q, cmpl_rob1_q;

    // An entry that is granted this cycle frees up at the edge. It can
    // therefore take a new result in the same cycle, which gives full
    // throughput without a second buffer slot.
    assign src_ready = {NUM_SRC{reset_n & ~flush}} & (~hold_vld_q | grant);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign in_pdst[gi] = src_pdst[gi*PREG_W +: PREG_W];
        assign in_data[gi] = src_data[gi*DATA_W +: DATA_W];
        assign in_rob[gi]  = src_rob[gi*ROB_W +: ROB_W];
        assign accept[gi]  = src_valid[gi] & src_ready[gi];
    end

    // Round-robin scan starting at rr_ptr. The first held entry goes to
    // port 0 and the second goes to port 1. The scan index is folded back
    // by one subtraction, because start + offset < 2*NUM_SRC.
    always_comb begin
        logic [IDX_W:0] pos;
        logic [IDX_W-1:0] sidx;
        g0_vld = 1'b0;
        g1_vld = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        grant  = '0;
        pos    = '0;
        sidx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_SRC)) begin
                pos = pos - (IDX_W+1)'(NUM_SRC);
            end
            sidx = pos[IDX_W-1:0];
            if (hold_vld_q[sidx]) begin
                if (!g0_vld) begin
                    g0_vld      = 1'b1;
                    g0_idx      = sidx;
                    grant[sidx] = 1'b1;
                end else if (!g1_vld) begin
                    g1_vld      = 1'b1;
                    g1_idx      = sidx;
                    grant[sidx] = 1'b1;
                end
            end
        end
    end

    // The pointer moves to the source just past the last one granted
    always_comb begin
        logic [IDX_W-1:0] last;
        last = g1_vld ? g1_idx : g0_idx;
        if (last == IDX_W'(NUM_SRC - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = last + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else if (!flush && g0_vld) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // A load and a grant of the same entry in one cycle must leave the
    // entry valid, so the load takes priority over the clear.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            hold_vld_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i]) begin
                    hold_vld_q[i] <= 1'b1;
                end else if (grant[i]) begin
                    hold_vld_q[i] <= 1'b0;
                end
            end
        end
    end

    // The payload needs no reset, because hold_vld_q qualifies it
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                hold_pdst_q[i] <= in_pdst[i];
                hold_data_q[i] <= in_data[i];
                hold_rob_q[i]  <= in_rob[i];
            end
        end
    end

    // Output stage. A result for preg 0 completes in the ROB but never
    // writes. Fields whose valid is low are zeroed.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wren0_q      <= 1'b0;
            wren1_q      <= 1'b0;
            waddr0_q     <= '0;
            waddr1_q     <= '0;
            wdata0_q     <= '0;
            wdata1_q     <= '0;
            cmpl_valid_q <= 2'b00;
            cmpl_rob0_q  <= '0;
            cmpl_rob1_q  <= '0;
        end else begin
            wren0_q      <= g0_vld && (hold_pdst_q[g0_idx] != '0);
            wren1_q      <= g1_vld && (hold_pdst_q[g1_idx] != '0);
            waddr0_q     <= g0_vld ? hold_pdst_q[g0_idx] : '0;
            waddr1_q     <= g1_vld ? hold_pdst_q[g1_idx] : '0;
            wdata0_q     <= g0_vld ? hold_data_q[g0_idx] : '0;
            wdata1_q     <= g1_vld ? hold_data_q[g1_idx] : '0;
            cmpl_valid_q <= {g1_vld, g0_vld};
            cmpl_rob0_q  <= g0_vld ? hold_rob_q[g0_idx] : '0;
            cmpl_rob1_q  <= g1_vld ? hold_rob_q[g1_idx] : '0;
        end
    end

    assign wren0      = wren0_q;
    assign wren1      = wren1_q;
    assign waddr0     = waddr0_q;
    assign waddr1     = waddr1_q;
    assign wdata0     = wdata0_q;
    assign wdata1     = wdata1_q;
    assign cmpl_valid = cmpl_valid_q;
    assign cmpl_rob0  = cmpl_rob0_q;
    assign cmpl_rob1  = cmpl_rob1_q;

`ifdef WB_PERF_CNT_EN
    // A counter counts the cycles in which its source offers a result that
    // is not taken. The counters survive a flush, so the totals cover the
    // whole run.
    logic [31:0] stall_cnt_q [NUM_SRC];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!reset_n) begin
                stall_cnt_q[i] <= '0;
            end else if (src_valid[i] && !src_ready[i]) begin
                stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_perf
        assign stall_cnt[gi*32 +: 32] = stall_cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_pregfile_wb_arbiter.sv
module tb_pregfile_wb_arbiter;

    localparam int NS = 3;
    localparam int P  = 6;
    localparam int D  = 64;
    localparam int R  = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*P-1:0]   src_pdst;
    logic [NS*D-1:0]   src_data;
    logic [NS*R-1:0]   src_rob;
    logic              wren0, wren1;
    logic [P-1:0]      waddr0, waddr1;
    logic [D-1:0]      wdata0, wdata1;
    logic [1:0]        cmpl_valid;
    logic [R-1:0]      cmpl_rob0, cmpl_rob1;
`ifdef WB_PERF_CNT_EN
    logic [NS*32-1:0]  stall_cnt;
`endif

    pregfile_wb_arbiter #(.NUM_SRC(NS), .PREG_W(P), .DATA_W(D), .ROB_W(R)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_pdst(src_pdst), .src_data(src_data), .src_rob(src_rob),
        .wren0(wren0), .waddr0(waddr0), .wdata0(wdata0),
        .wren1(wren1), .waddr1(waddr1), .wdata1(wdata1),
        .cmpl_valid(cmpl_valid), .cmpl_rob0(cmpl_rob0), .cmpl_rob1(cmpl_rob1)
`ifdef WB_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each source has a mailbox of at most one result. The model pairs
    // results with ports by a rotating priority order. It keeps the outputs
    // that the write ports are expected to show next.
    bit          m_hold [NS];
    logic [P-1:0] m_pdst [NS];
    logic [D-1:0] m_data [NS];
    logic [R-1:0] m_rob  [NS];
    int          m_rr;
    logic [31:0] m_stall [NS];
    bit          e_w0, e_w1;
    logic [P-1:0] e_a0, e_a1;
    logic [D-1:0] e_d0, e_d1;
    logic [1:0]  e_cv;
    logic [R-1:0] e_r0, e_r1;

    function automatic void get_grants(output int g0, output int g1);
        g0 = -1; g1 = -1;
        for (int k = 0; k < NS; k++) begin
            int s = (m_rr + k) % NS;
            if (m_hold[s]) begin
                if (g0 < 0) g0 = s;
                else if (g1 < 0) g1 = s;
            end
        end
    endfunction

    function automatic logic [NS-1:0] model_ready();
        int g0, g1;
        logic [NS-1:0] r;
        get_grants(g0, g1);
        for (int i = 0; i < NS; i++)
            r[i] = reset_n && !flush && (!m_hold[i] || i == g0 || i == g1);
        return r;
    endfunction

    function automatic void clear_outs();
        e_w0 = 0; e_w1 = 0; e_a0 = 0; e_a1 = 0; e_d0 = 0; e_d1 = 0;
        e_cv = 0; e_r0 = 0; e_r1 = 0;
    endfunction

    function automatic void model_edge();
        int g0, g1;
        logic [NS-1:0] rdy;
        get_grants(g0, g1);
        rdy = model_ready();
        for (int i = 0; i < NS; i++) begin
            if (!reset_n) m_stall[i] = 0;
            else if (src_valid[i] && !rdy[i]) m_stall[i] = m_stall[i] + 1;
        end
        if (!reset_n || flush) begin
            for (int i = 0; i < NS; i++) m_hold[i] = 0;
            if (!reset_n) m_rr = 0;
            clear_outs();
        end else begin
            clear_outs();
            if (g0 >= 0) begin
                e_cv[0] = 1; e_w0 = (m_pdst[g0] != 0);
                e_a0 = m_pdst[g0]; e_d0 = m_data[g0]; e_r0 = m_rob[g0];
                m_hold[g0] = 0;
                m_rr = (g0 + 1) % NS;
            end
            if (g1 >= 0) begin
                e_cv[1] = 1; e_w1 = (m_pdst[g1] != 0);
                e_a1 = m_pdst[g1]; e_d1 = m_data[g1]; e_r1 = m_rob[g1];
                m_hold[g1] = 0;
                m_rr = (g1 + 1) % NS;
            end
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && rdy[i]) begin
                    m_hold[i] = 1;
                    m_pdst[i] = src_pdst[i*P +: P];
                    m_data[i] = src_data[i*D +: D];
                    m_rob[i]  = src_rob[i*R +: R];
                end
            end
        end
    endfunction

    task automatic check_model();
        chk("m_ready", 64'(src_ready), 64'(model_ready()));
        chk("m_wren0", 64'(wren0), 64'(e_w0));
        chk("m_waddr0", 64'(waddr0), 64'(e_a0));
        chk("m_wdata0", wdata0, e_d0);
        chk("m_wren1", 64'(wren1), 64'(e_w1));
        chk("m_waddr1", 64'(waddr1), 64'(e_a1));
        chk("m_wdata1", wdata1, e_d1);
        chk("m_cmpl_valid", 64'(cmpl_valid), 64'(e_cv));
        chk("m_cmpl_rob0", 64'(cmpl_rob0), 64'(e_r0));
        chk("m_cmpl_rob1", 64'(cmpl_rob1), 64'(e_r1));
`ifdef WB_PERF_CNT_EN
        for (int i = 0; i < NS; i++)
            chk($sformatf("m_stall%0d", i), 64'(stall_cnt[i*32 +: 32]), 64'(m_stall[i]));
`endif
    endtask

    task automatic drive(input bit rst, input bit fl, input logic [NS-1:0] v,
                         input logic [NS*P-1:0] p, input logic [NS*D-1:0] d,
                         input logic [NS*R-1:0] r);
        reset_n = rst; flush = fl; src_valid = v;
        src_pdst = p; src_data = d; src_rob = r;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit           rst_n;
        bit           fl;
        logic [2:0]   v;
        logic [17:0]  p;
        logic [191:0] d;
        logic [17:0]  r;
        logic [2:0]   rdy;
        bit           w0;
        logic [5:0]   a0;
        logic [63:0]  d0;
        bit           w1;
        logic [5:0]   a1;
        logic [63:0]  d1;
        logic [1:0]   cv;
        logic [5:0]   r0;
        logic [5:0]   r1;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(bit rst, bit fl, logic [2:0] v,
                                logic [5:0] p2, logic [5:0] p1, logic [5:0] p0,
                                logic [63:0] d2, logic [63:0] d1, logic [63:0] d0,
                                logic [5:0] r2, logic [5:0] r1, logic [5:0] r0,
                                logic [2:0] rdy, bit w0, logic [5:0] a0, logic [63:0] od0,
                                bit w1, logic [5:0] a1, logic [63:0] od1,
                                logic [1:0] cv, logic [5:0] or0, logic [5:0] or1);
        vec_t t;
        t.rst_n = rst; t.fl = fl; t.v = v;
        t.p = {p2, p1, p0}; t.d = {d2, d1, d0}; t.r = {r2, r1, r0};
        t.rdy = rdy; t.w0 = w0; t.a0 = a0; t.d0 = od0;
        t.w1 = w1; t.a1 = a1; t.d1 = od1; t.cv = cv; t.r0 = or0; t.r1 = or1;
        return t;
    endfunction

    initial begin
        int writes2;
        // rows: rst fl v | p2 p1 p0 | d2 d1 d0 | r2 r1 r0 || rdy w0 a0 d0 w1 a1 d1 cv r0 r1
        tbl[0]  = mk(0,0,3'b111, 9,9,9, 1,1,1, 1,1,1,       3'b000, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[1]  = mk(1,0,3'b001, 0,0,5, 0,0,64'hDEADBEEF, 0,0,3, 3'b111, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[2]  = mk(1,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b111, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[3]  = mk(1,0,3'b010, 0,0,0, 0,0,0, 0,7,0,       3'b111, 1,5,64'hDEADBEEF, 0,0,0, 2'b01,3,0);
        tbl[4]  = mk(1,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b111, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[5]  = mk(1,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b111, 0,0,0, 0,0,0, 2'b01,7,0);
        tbl[6]  = mk(1,0,3'b111, 12,11,10, 'hA2,'hA1,'hA0, 22,21,20, 3'b111, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[7]  = mk(1,0,3'b111, 15,14,13, 'hB2,'hB1,'hB0, 25,24,23, 3'b101, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[8]  = mk(1,1,3'b111, 15,14,13, 'hB2,'hB1,'hB0, 25,24,23, 3'b000,
                     1,12,'hA2, 1,10,'hA0, 2'b11,22,20);
        tbl[9]  = mk(1,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b111, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[10] = mk(1,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b111, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[11] = mk(1,0,3'b011, 0,2,1, 0,'hC1,'hC0, 0,2,1, 3'b111, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[12] = mk(1,0,3'b100, 3,0,0, 'hC2,0,0, 3,0,0,    3'b111, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[13] = mk(0,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b000,
                     1,2,'hC1, 1,1,'hC0, 2'b11,2,1);
        tbl[14] = mk(1,0,3'b111, 8,6,4, 'hD2,'hD1,'hD0, 6,5,4, 3'b111, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[15] = mk(1,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b011, 0,0,0, 0,0,0, 2'b00,0,0);
        tbl[16] = mk(1,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b111,
                     1,4,'hD0, 1,6,'hD1, 2'b11,4,5);
        tbl[17] = mk(1,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b111, 1,8,'hD2, 0,0,0, 2'b01,6,0);
        tbl[18] = mk(1,0,3'b000, 0,0,0, 0,0,0, 0,0,0,       3'b111, 0,0,0, 0,0,0, 2'b00,0,0);

        // initial reset; model starts in its reset state
        for (int i = 0; i < NS; i++) begin
            m_hold[i] = 0; m_pdst[i] = 0; m_data[i] = 0; m_rob[i] = 0; m_stall[i] = 0;
        end
        m_rr = 0;
        clear_outs();
        reset_n = 0; flush = 0; src_valid = 0; src_pdst = 0; src_data = 0; src_rob = 0;
        @(posedge clk);
        @(negedge clk);

        // directed table
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst_n, tbl[i].fl, tbl[i].v, tbl[i].p, tbl[i].d, tbl[i].r);
            chk($sformatf("t%0d_ready", i), 64'(src_ready), 64'(tbl[i].rdy));
            chk($sformatf("t%0d_wren0", i), 64'(wren0), 64'(tbl[i].w0));
            chk($sformatf("t%0d_waddr0", i), 64'(waddr0), 64'(tbl[i].a0));
            chk($sformatf("t%0d_wdata0", i), wdata0, tbl[i].d0);
            chk($sformatf("t%0d_wren1", i), 64'(wren1), 64'(tbl[i].w1));
            chk($sformatf("t%0d_waddr1", i), 64'(waddr1), 64'(tbl[i].a1));
            chk($sformatf("t%0d_wdata1", i), wdata1, tbl[i].d1);
            chk($sformatf("t%0d_cmpl_valid", i), 64'(cmpl_valid), 64'(tbl[i].cv));
            chk($sformatf("t%0d_cmpl_rob0", i), 64'(cmpl_rob0), 64'(tbl[i].r0));
            chk($sformatf("t%0d_cmpl_rob1", i), 64'(cmpl_rob1), 64'(tbl[i].r1));
            check_model();
            clock_edge();
        end

        // sustained throughput: all three sources valid every cycle
        drive(0, 0, 3'b000, '0, '0, '0);
        check_model();
        clock_edge();
        writes2 = 0;
        for (int c = 0; c < 8; c++) begin
            logic [NS*P-1:0] p;
            logic [NS*D-1:0] d;
            for (int i = 0; i < NS; i++) begin
                p[i*P +: P] = P'(1 + i + 3 * (c % 20));
                d[i*D +: D] = {$urandom, $urandom};
            end
            drive(1, 0, 3'b111, p, d, NS*R'($urandom));
            if (c >= 2) begin
                chk($sformatf("tp%0d_cmpl_valid", c), 64'(cmpl_valid), 64'(2'b11));
                if (wren0 && wren1) writes2++;
            end
            check_model();
            clock_edge();
        end
        chk("tp_dual_write_cycles", 64'(writes2), 64'd6);

`ifdef WB_PERF_CNT_EN
        // stall counting: src2 is held valid while src0/src1 saturate
        drive(0, 0, 3'b000, '0, '0, '0);
        check_model();
        clock_edge();
        for (int c = 0; c < 10; c++) begin
            drive(1, 0, 3'b111, {6'd3, 6'd2, 6'd1}, '0, '0);
            check_model();
            clock_edge();
        end
        drive(1, 0, 3'b000, '0, '0, '0);
        chk("perf_stall_src2", 64'(stall_cnt[2*32 +: 32]), 64'd3);
        check_model();
        clock_edge();
`endif

        // randomized traffic with occasional flush and reset
        for (int c = 0; c < 400; c++) begin
            logic [NS*P-1:0] p;
            logic [NS*D-1:0] d;
            logic [NS*R-1:0] r;
            bit rst, fl;
            for (int i = 0; i < NS; i++) begin
                p[i*P +: P] = ($urandom_range(0, 7) == 0) ? P'(0) : P'($urandom);
                d[i*D +: D] = {$urandom, $urandom};
                r[i*R +: R] = R'($urandom);
            end
            rst = ($urandom_range(0, 49) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            drive(rst, fl, NS'($urandom), p, d, r);
            check_model();
            clock_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
